mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage responder for the data-memory controls the decoder emits: mem_read_en, mem_write_en and l_s_mode (byte, byte-unsigned, half, half-unsigned, word).
- Turns one load/store request into a word-aligned, byte-enabled bus transaction with a req/ack handshake.
- Stalls the pipeline until the transaction completes.
- Returns sign/zero-extended load data, and flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32, other values unsupported
- TIMEOUT, 255, BUSY cycles without bus_ack before bus_err; must be 1..255

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read_en  in  1  load request from MEM stage
- mem_write_en  in  1  store request from MEM stage
- l_s_mode  in  `L_S_MODE_W  access size and extension
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  DATA_W  store data ([rt])
- stall  out  1  hold MEM stage and upstream
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  extended load result, valid while done=1
- misaligned  out  1  address-error flag, valid while done=1
- bus_err  out  1  timeout or illegal-request flag, valid while done=1
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word address, bits [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_W  lane-replicated write data
- bus_ack  in  1  transfer complete; bus_rdata valid in the same cycle
- bus_rdata  in  DATA_W  read word

Behaviour:
- Reset (asynchronous, immediate): state IDLE; these registered outputs clear to 0: done, rdata, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata. Timeout counter clears to 0. stall is combinational and is also 0 in reset because the state is IDLE. Reset mid-transaction drops bus_req at once and does not wait for ack.
- Byte lanes are little-endian: byte k is addr[1:0]=k, bus_be[k], bits [8k+7:8k].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
- Byte enables: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
- Write data: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata as-is.
- Read extraction: take the selected lane(s) from bus_rdata. BYTE and HALF sign-extend; BYTE_U and HALF_U zero-extend. Any other mode value behaves as WORD.
- stall = (state==IDLE && (mem_read_en || mem_write_en)) || state==BUSY. It is 0 in DONE.
- FSM:
  - IDLE, no request: stay IDLE; all outputs idle.
  - IDLE, exactly one of read/write, aligned: latch the bus fields, set bus_req=1 and bus_we=mem_write_en, go to BUSY. The bus sees the request the cycle after it is presented.
  - IDLE, misaligned: no bus access; go to DONE with misaligned=1 and rdata=0.
  - IDLE, read and write both high: no bus access; go to DONE with bus_err=1.
  - BUSY: hold all bus fields stable while bus_ack=0, and increment the counter.
  - BUSY, bus_ack=1: capture the extended rdata (0 for a write), bus_req=0, go to DONE. Latency with zero wait states: request cycle, then BUSY, then DONE, i.e. stall high for 2 cycles.
  - BUSY, counter reaches TIMEOUT-1 with no ack: bus_req=0, bus_err=1, go to DONE. An ack in that same cycle wins: complete normally, no error.
  - DONE: done=1, stall=0 for one cycle. Request inputs are ignored (they still belong to the completing instruction). Go to IDLE, clearing done, misaligned and bus_err; rdata holds its value.
- bus_ack while not in BUSY is ignored.
- Back-to-back accesses: at least one IDLE cycle between transactions, so each access costs a minimum of 3 cycles.

Test Plan:
- Load byte, signed: mode BYTE, addr=0x1003, bus_rdata=0x80112233, ack in first BUSY cycle -> bus_addr=0x1000, bus_be=1000, stall high 2 cycles, done pulse with rdata=0xFFFFFF80.
- Load half, unsigned, 3 wait states: mode HALF_U, addr=0x2002, bus_rdata=0xBEEF0000 -> bus_req held 4 cycles with fields stable, rdata=0x0000BEEF, stall high 5 cycles.
- Store half: mode HALF, addr=0x10, wdata=0x1234ABCD -> bus_we=1, bus_be=0011, bus_wdata=0xABCDABCD, done with rdata=0.
- Misaligned word: mode WORD, addr=0x101 -> bus_req never asserts; next cycle done=1, misaligned=1; then IDLE.
- Timeout: TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then done=1 and bus_err=1. Repeat with ack in the 4th cycle -> bus_err=0.
- Reset mid-BUSY: rst_n low while bus_req=1 -> bus_req and stall 0 immediately; after release, a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: turns one decoder request into a word-aligned,
// byte-enabled req/ack bus transaction, stalling the pipeline until it completes.
`ifndef L_S_MODE_W
`define L_S_MODE_W 3
`endif

module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [`L_S_MODE_W-1:0] l_s_mode,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   stall,
    output logic                   done,
    output logic [DATA_W-1:0]      rdata,
    output logic                   misaligned,
    output logic                   bus_err,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [3:0]             bus_be,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic                   bus_ack,
    input  logic [DATA_W-1:0]      bus_rdata
);
    localparam logic [`L_S_MODE_W-1:0] MODE_BYTE   = `L_S_MODE_W'd0;
    localparam logic [`L_S_MODE_W-1:0] MODE_BYTE_U = `L_S_MODE_W'd1;
    localparam logic [`L_S_MODE_W-1:0] MODE_HALF   = `L_S_MODE_W'd2;
    localparam logic [`L_S_MODE_W-1:0] MODE_HALF_U = `L_S_MODE_W'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_reg;
    logic [7:0]             cnt_reg;
    logic [`L_S_MODE_W-1:0] mode_reg;
    logic [1:0]             off_reg;

    logic                   aligned;
    logic [3:0]             be_next;
    logic [DATA_W-1:0]      wdata_next;
    logic [DATA_W-1:0]      shifted;
    logic [7:0]             lane_byte;
    logic [15:0]            lane_half;
    logic [DATA_W-1:0]      ext_rdata;

    assign stall = rst_n && (((state_reg == IDLE) && (mem_read_en || mem_write_en))
                             || (state_reg == BUSY));

    // Unknown mode encodings fall through to word behaviour everywhere.
    always_comb begin
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (l_s_mode)
            MODE_BYTE, MODE_BYTE_U: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            MODE_HALF, MODE_HALF_U: begin
                aligned    = ~addr[0];
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        shifted   = bus_rdata >> {off_reg, 3'b000};
        lane_byte = shifted[7:0];
        lane_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (mode_reg)
            MODE_BYTE:   ext_rdata = {{24{lane_byte[7]}}, lane_byte};
            MODE_BYTE_U: ext_rdata = {24'd0, lane_byte};
            MODE_HALF:   ext_rdata = {{16{lane_half[15]}}, lane_half};
            MODE_HALF_U: ext_rdata = {16'd0, lane_half};
            default:     ext_rdata = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            mode_reg   <= '0;
            off_reg    <= 2'b00;
            done       <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_read_en && mem_write_en) begin
                        bus_err   <= 1'b1;
                        rdata     <= '0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (mem_read_en || mem_write_en) begin
                        if (!aligned) begin
                            misaligned <= 1'b1;
                            rdata      <= '0;
                            done       <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write_en;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            mode_reg  <= l_s_mode;
                            off_reg   <= addr[1:0];
                            cnt_reg   <= 8'd0;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (bus_ack) begin
                        rdata     <= bus_we ? '0 : ext_rdata;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'b0000;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                        bus_err   <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'b0000;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    bus_err    <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small bus responder that acks on a chosen cycle.
`ifndef L_S_MODE_W
`define L_S_MODE_W 3
`endif

module tb_mem_access_unit;
    localparam logic [2:0] M_BYTE = 3'd0, M_BYTE_U = 3'd1, M_HALF = 3'd2,
                           M_HALF_U = 3'd3, M_WORD = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  l_s_mode;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    int          n_stall, n_req;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic        o_mis, o_err, o_we, o_stable, o_done;
    logic [3:0]  o_be;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .l_s_mode(l_s_mode), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Presents one request and plays the bus; ack_at = BUSY cycle that acks (0 = never).
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] mode,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] brd, input int ack_at);
        n_stall = 0; n_req = 0; o_rdata = '0; o_mis = 0; o_err = 0; o_we = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_stable = 1; o_done = 0;
        @(negedge clk);
        mem_read_en = rd; mem_write_en = wr; l_s_mode = mode;
        addr = a; wdata = wd; bus_rdata = brd; bus_ack = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall) n_stall++;
            if (bus_req) begin
                n_req++;
                if (n_req == 1) begin
                    o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
                end else if (bus_addr !== o_addr || bus_be !== o_be ||
                             bus_we !== o_we || bus_wdata !== o_wdata) begin
                    o_stable = 0;
                end
                bus_ack = (n_req == ack_at);
            end else begin
                bus_ack = 0;
            end
            if (done) begin
                o_done = 1; o_rdata = rdata; o_mis = misaligned; o_err = bus_err;
                mem_read_en = 0; mem_write_en = 0; bus_ack = 0;
                break;
            end
            @(negedge clk);
        end
        mem_read_en = 0; mem_write_en = 0; bus_ack = 0;
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL done_seen: got %0b want 1 (addr=%h)", o_done, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; mem_read_en = 0; mem_write_en = 0; l_s_mode = M_WORD;
        addr = '0; wdata = '0; bus_ack = 0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus_req); end
        checks++; if (bus_be !== 4'b0) begin errors++; $display("FAIL rst_be: got %b want 0000", bus_be); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        @(negedge clk);
        rst_n = 1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_load_byte();
        run_txn(1, 0, M_BYTE, 32'h1003, 32'h0, 32'h80112233, 1);
        checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", o_addr); end
        checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", o_be); end
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", o_we); end
        checks++; if (n_stall != 2) begin errors++; $display("FAIL lb_stall: got %0d want 2", n_stall); end
        checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
        checks++; if (o_err !== 1'b0 || o_mis !== 1'b0) begin errors++; $display("FAIL lb_flags: got err=%b mis=%b want 0 0", o_err, o_mis); end
        $display("load byte: rdata=%h stall=%0d", o_rdata, n_stall);
    endtask

    task automatic test_load_half_u_wait();
        run_txn(1, 0, M_HALF_U, 32'h2002, 32'h0, 32'hBEEF0000, 4);
        checks++; if (n_req != 4) begin errors++; $display("FAIL lhu_req: got %0d want 4", n_req); end
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL lhu_stable: got %b want 1", o_stable); end
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL lhu_be: got %b want 1100", o_be); end
        checks++; if (o_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_rdata: got %h want 0000beef", o_rdata); end
        checks++; if (n_stall != 5) begin errors++; $display("FAIL lhu_stall: got %0d want 5", n_stall); end
        $display("load half_u 3 waits: rdata=%h stall=%0d", o_rdata, n_stall);
    endtask

    task automatic test_store_half();
        run_txn(0, 1, M_HALF, 32'h10, 32'h1234ABCD, 32'hFFFFFFFF, 1);
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", o_we); end
        checks++; if (o_be !== 4'b0011) begin errors++; $display("FAIL sh_be: got %b want 0011", o_be); end
        checks++; if (o_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
        checks++; if (o_addr !== 32'h10) begin errors++; $display("FAIL sh_addr: got %h want 00000010", o_addr); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h want 0", o_rdata); end
        $display("store half: wdata=%h be=%b", o_wdata, o_be);
    endtask

    task automatic test_misaligned();
        run_txn(1, 0, M_WORD, 32'h101, 32'h0, 32'h12345678, 1);
        checks++; if (n_req != 0) begin errors++; $display("FAIL mis_req: got %0d want 0", n_req); end
        checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", o_mis); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", o_rdata); end
        checks++; if (n_stall != 1) begin errors++; $display("FAIL mis_stall: got %0d want 1", n_stall); end
        @(negedge clk); #1;
        checks++; if (misaligned !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mis_clear: got mis=%b done=%b want 0 0", misaligned, done); end
        $display("misaligned word: mis=%b", o_mis);
    endtask

    task automatic test_timeout();
        run_txn(1, 0, M_WORD, 32'h200, 32'h0, 32'h55AA55AA, 0);
        checks++; if (n_req != 4) begin errors++; $display("FAIL to_req: got %0d want 4", n_req); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", o_err); end
        $display("timeout no ack: req=%0d err=%b", n_req, o_err);
        run_txn(1, 0, M_WORD, 32'h204, 32'h0, 32'h55AA55AA, 4);
        checks++; if (n_req != 4) begin errors++; $display("FAIL to_ack_req: got %0d want 4", n_req); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL to_ack_err: got %b want 0", o_err); end
        checks++; if (o_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL to_ack_rdata: got %h want 55aa55aa", o_rdata); end
        $display("timeout ack on last: err=%b rdata=%h", o_err, o_rdata);
    endtask

    task automatic test_illegal();
        run_txn(1, 1, M_WORD, 32'h300, 32'h0, 32'h0, 1);
        checks++; if (n_req != 0) begin errors++; $display("FAIL ill_req: got %0d want 0", n_req); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b want 1", o_err); end
        $display("read+write: err=%b", o_err);
    endtask

    task automatic test_back_to_back();
        run_txn(1, 0, M_BYTE_U, 32'h3001, 32'h0, 32'h0000F200, 1);
        checks++; if (o_rdata !== 32'h000000F2) begin errors++; $display("FAIL bu_rdata: got %h want 000000f2", o_rdata); end
        checks++; if (o_be !== 4'b0010) begin errors++; $display("FAIL bu_be: got %b want 0010", o_be); end
        run_txn(1, 0, M_HALF, 32'h3002, 32'h0, 32'h80011234, 1);
        checks++; if (o_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL hs_rdata: got %h want ffff8001", o_rdata); end
        run_txn(1, 0, M_WORD, 32'h3004, 32'h0, 32'hDEADBEEF, 1);
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
        checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b want 1111", o_be); end
        $display("back-to-back loads: last rdata=%h", o_rdata);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        mem_read_en = 1; l_s_mode = M_WORD; addr = 32'h40; bus_rdata = 32'h0; bus_ack = 0;
        @(negedge clk); #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mr_req_up: got %b want 1", bus_req); end
        rst_n = 0; mem_read_en = 0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mr_req_drop: got %b want 0", bus_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mr_stall: got %b want 0", stall); end
        @(negedge clk);
        rst_n = 1;
        run_txn(1, 0, M_WORD, 32'h44, 32'h0, 32'h01020304, 1);
        checks++; if (o_rdata !== 32'h01020304) begin errors++; $display("FAIL mr_rdata: got %h want 01020304", o_rdata); end
        checks++; if (n_stall != 2) begin errors++; $display("FAIL mr_stall2: got %0d want 2", n_stall); end
        $display("reset mid-busy then load: rdata=%h", o_rdata);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_u_wait();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
